rf_access_ctrl: RTL and testbench

//   Sequences and shares the 32x32 register file (2 read ports, 1 write port,
//   1-cycle registered reads) between the CPU core and the debug/loader port.

---
 rtl/rf_access_ctrl.sv | 76 +++++++
 tb/tb_rf_access_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: clears the register file after reset, then shares its write port and read port B
// between the core (priority) and a debug port whose waiting time is bounded.
module rf_access_ctrl #(
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_w_en,
  input  logic [AW-1:0] core_w_addr,
  input  logic [DW-1:0] core_w_data,
  input  logic [AW-1:0] core_ra_addr,
  input  logic [AW-1:0] core_rb_addr,
  input  logic          core_rb_use,
  output logic          core_stall,
  output logic          init_busy,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          rf_w_ena,
  output logic [AW-1:0] rf_w_addr,
  output logic [DW-1:0] rf_w_data,
  output logic [AW-1:0] rf_ra_addr,
  output logic [AW-1:0] rf_rb_addr,
  input  logic [DW-1:0] rf_ra_data,
  input  logic [DW-1:0] rf_rb_data
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d, w_addr;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic dbg_rvalid_q, dbg_rvalid_d, run, dbg_ok, frc, dbg_wr;
  always_comb begin
    run          = state_q == RUN;
    dbg_ok       = run & dbg_req & (dbg_we ? ~core_w_en : ~core_rb_use);
    frc          = run & dbg_req & ~dbg_ok & (wait_cnt_q == WMAX);
    dbg_gnt      = dbg_ok | frc;
    dbg_wr       = dbg_gnt & dbg_we;
    w_addr       = dbg_wr ? dbg_addr : core_w_addr;
    init_busy    = ~run;
    core_stall   = ~run | frc;
    // x0 is hard-wired zero, except for the clear sequence itself
    rf_w_ena     = run ? (dbg_wr | (core_w_en & ~frc)) & (w_addr != '0) : 1'b1;
    rf_w_addr    = run ? w_addr : clr_cnt_q;
    rf_w_data    = run ? (dbg_wr ? dbg_wdata : core_w_data) : '0;
    rf_ra_addr   = core_ra_addr;
    rf_rb_addr   = (dbg_gnt & ~dbg_we) ? dbg_addr : core_rb_addr;
    dbg_rvalid   = dbg_rvalid_q;
    dbg_rdata    = rf_rb_data;
    state_d      = (!run && clr_cnt_q == AW'(NREGS - 1)) ? RUN : state_q;
    clr_cnt_d    = run ? clr_cnt_q : clr_cnt_q + 1'b1;
    wait_cnt_d   = (dbg_gnt | ~dbg_req | ~run) ? '0 : wait_cnt_q + CW'(wait_cnt_q != WMAX);
    dbg_rvalid_d = dbg_gnt & ~dbg_we;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= INIT;
      clr_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end
endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: directed bench for rf_access_ctrl with a small forwarding register file model.
module tb_rf_access_ctrl;
  logic clk = 1'b0, rst;
  logic core_w_en, core_rb_use, core_stall, init_busy;
  logic [4:0] core_w_addr, core_ra_addr, core_rb_addr;
  logic [31:0] core_w_data;
  logic dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [4:0] dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic rf_w_ena;
  logic [4:0] rf_w_addr, rf_ra_addr, rf_rb_addr;
  logic [31:0] rf_w_data, rf_ra_data, rf_rb_data;
  logic [31:0] mem [32];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  rf_access_ctrl dut (
    .clk(clk), .rst(rst),
    .core_w_en(core_w_en), .core_w_addr(core_w_addr), .core_w_data(core_w_data),
    .core_ra_addr(core_ra_addr), .core_rb_addr(core_rb_addr), .core_rb_use(core_rb_use),
    .core_stall(core_stall), .init_busy(init_busy),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .rf_w_ena(rf_w_ena), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data)
  );
  // register file: registered reads that forward a same-cycle write
  initial for (int i = 0; i < 32; i++) mem[i] = 32'hFFFF_FFFF;
  always @(posedge clk) begin
    if (rf_w_ena) mem[rf_w_addr] <= rf_w_data;
    rf_ra_data <= (rf_w_ena && rf_w_addr == rf_ra_addr) ? rf_w_data : mem[rf_ra_addr];
    rf_rb_data <= (rf_w_ena && rf_w_addr == rf_rb_addr) ? rf_w_data : mem[rf_rb_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic run_init(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("init_ena", 32'(rf_w_ena), 1);
      chk("init_addr", 32'(rf_w_addr), i);
      chk("init_data", rf_w_data, 0);
      chk("init_busy", 32'(init_busy), 1);
      chk("init_stall", 32'(core_stall), 1);
      chk("init_gnt", 32'(dbg_gnt), 0);
      nxt();
    end
  endtask
  initial begin
    rst = 1'b1;
    core_w_en = 0; core_w_addr = 0; core_w_data = 0; core_ra_addr = 0;
    core_rb_addr = 0; core_rb_use = 0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 3; dbg_wdata = 32'h3333_3333;
    #2;
    chk("rst_busy", 32'(init_busy), 1);
    chk("rst_stall", 32'(core_stall), 1);
    chk("rst_gnt", 32'(dbg_gnt), 0);
    chk("rst_rvalid", 32'(dbg_rvalid), 0);
    nxt(); nxt();
    rst = 1'b0;
    run_init(32);
    dbg_req = 0;
    #1;
    chk("run_busy", 32'(init_busy), 0);
    chk("run_stall", 32'(core_stall), 0);
    nxt();
    // core writes to x0 are dropped, x5 lands
    core_w_en = 1; core_w_addr = 0; core_w_data = 32'hDEAD_BEEF;
    #1; chk("x0_ena", 32'(rf_w_ena), 0); nxt();
    core_w_addr = 5; core_w_data = 32'h1234_5678;
    #1;
    chk("x5_ena", 32'(rf_w_ena), 1);
    chk("x5_addr", 32'(rf_w_addr), 5);
    chk("x5_data", rf_w_data, 32'h1234_5678);
    nxt();
    core_w_en = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 0;
    #1; chk("rd0_gnt", 32'(dbg_gnt), 1); chk("rd0_rb", 32'(rf_rb_addr), 0); nxt();
    dbg_req = 0;
    #1; chk("rd0_rvalid", 32'(dbg_rvalid), 1); chk("rd0_data", dbg_rdata, 0); nxt();
    dbg_req = 1; dbg_addr = 5;
    #1; chk("rd5_gnt", 32'(dbg_gnt), 1); nxt();
    dbg_req = 0;
    #1; chk("rd5_rvalid", 32'(dbg_rvalid), 1); chk("rd5_data", dbg_rdata, 32'h1234_5678); nxt();
    #1; chk("rvalid_pulse", 32'(dbg_rvalid), 0); nxt();
    // uncontended debug write, then core reads it back on port A
    dbg_req = 1; dbg_we = 1; dbg_addr = 7; dbg_wdata = 32'hA5A5_A5A5;
    #1;
    chk("dw_gnt", 32'(dbg_gnt), 1);
    chk("dw_stall", 32'(core_stall), 0);
    chk("dw_ena", 32'(rf_w_ena), 1);
    chk("dw_addr", 32'(rf_w_addr), 7);
    chk("dw_data", rf_w_data, 32'hA5A5_A5A5);
    nxt();
    dbg_req = 0; core_ra_addr = 7;
    #1; chk("ra_addr", 32'(rf_ra_addr), 7); chk("dw_rvalid", 32'(dbg_rvalid), 0); nxt();
    #1; chk("ra_data", rf_ra_data, 32'hA5A5_A5A5); nxt();
    // contended debug write: three denials, then forced grant
    core_w_en = 1; core_w_addr = 10; core_w_data = 32'h1111_1111;
    dbg_req = 1; dbg_we = 1; dbg_addr = 11; dbg_wdata = 32'h2222_2222;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fw_deny_gnt", 32'(dbg_gnt), 0);
      chk("fw_deny_stall", 32'(core_stall), 0);
      chk("fw_deny_addr", 32'(rf_w_addr), 10);
      chk("fw_deny_ena", 32'(rf_w_ena), 1);
      nxt();
    end
    #1;
    chk("fw_gnt", 32'(dbg_gnt), 1);
    chk("fw_stall", 32'(core_stall), 1);
    chk("fw_addr", 32'(rf_w_addr), 11);
    chk("fw_data", rf_w_data, 32'h2222_2222);
    nxt();
    dbg_req = 0;
    #1;
    chk("retire_gnt", 32'(dbg_gnt), 0);
    chk("retire_stall", 32'(core_stall), 0);
    chk("retire_ena", 32'(rf_w_ena), 1);
    chk("retire_addr", 32'(rf_w_addr), 10);
    chk("retire_data", rf_w_data, 32'h1111_1111);
    nxt();
    core_w_addr = 9; core_w_data = 32'h9999_0009;
    #1; nxt();
    core_w_en = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 9;
    #1; chk("rd9_gnt", 32'(dbg_gnt), 1); chk("rd9_rb", 32'(rf_rb_addr), 9); nxt();
    dbg_req = 0;
    #1; chk("rd9_rvalid", 32'(dbg_rvalid), 1); chk("rd9_data", dbg_rdata, 32'h9999_0009); nxt();
    // contended debug read, forced grant, then back-to-back grant on the rvalid cycle
    core_rb_use = 1; core_rb_addr = 4; dbg_req = 1; dbg_addr = 5;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fr_deny_gnt", 32'(dbg_gnt), 0);
      chk("fr_deny_rb", 32'(rf_rb_addr), 4);
      chk("fr_deny_rvalid", 32'(dbg_rvalid), 0);
      nxt();
    end
    #1;
    chk("fr_gnt", 32'(dbg_gnt), 1);
    chk("fr_stall", 32'(core_stall), 1);
    chk("fr_rb", 32'(rf_rb_addr), 5);
    nxt();
    core_rb_use = 0; dbg_addr = 7;
    #1;
    chk("fr_rvalid", 32'(dbg_rvalid), 1);
    chk("fr_data", dbg_rdata, 32'h1234_5678);
    chk("b2b_gnt", 32'(dbg_gnt), 1);
    chk("b2b_rb", 32'(rf_rb_addr), 7);
    nxt();
    dbg_req = 0;
    #1; chk("b2b_rvalid", 32'(dbg_rvalid), 1); chk("b2b_data", dbg_rdata, 32'hA5A5_A5A5); nxt();
    // reset right after a read grant drops the rvalid; reset mid-clear restarts it
    dbg_req = 1; dbg_addr = 5;
    #1; chk("pre_rst_gnt", 32'(dbg_gnt), 1);
    #1; rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(init_busy), 1);
    chk("mid_rst_gnt", 32'(dbg_gnt), 0);
    dbg_req = 0;
    nxt();
    #1; chk("drop_rvalid", 32'(dbg_rvalid), 0);
    nxt();
    rst = 1'b0;
    run_init(10);
    #1; chk("c10_addr", 32'(rf_w_addr), 10);
    rst = 1'b1;
    #1; chk("c10_rst_addr", 32'(rf_w_addr), 0); chk("c10_rst_busy", 32'(init_busy), 1);
    nxt();
    rst = 1'b0;
    run_init(32);
    #1; chk("reinit_busy", 32'(init_busy), 0);
    nxt();
    dbg_req = 1; dbg_we = 0; dbg_addr = 5;
    #1; chk("clr5_gnt", 32'(dbg_gnt), 1); nxt();
    dbg_req = 0;
    #1; chk("clr5_rvalid", 32'(dbg_rvalid), 1); chk("clr5_data", dbg_rdata, 0); nxt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
